rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter sharing the register file's single write port among `NUM_REQ` result producers (ALU, LSU, CSR, ...). It accepts one write per cycle through a valid/ready handshake, uses round-robin priority, and registers the winning write in a one-entry stage that drives the register file write port. It sits between the execute/memory units and `rf`. It also exports a pending-write mask for hazard detection.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters; legal range 2..8.
- `REG_NUM`, 16: number of architectural registers; x0 is hard-wired zero.
- `REG_A_W`, 5: register address width.
- `REG_W`, 32: register data width.

Ports:
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: requester i has a write pending.
- `req_rd` in `NUM_REQ`×`REG_A_W`: destination register per requester.
- `req_data` in `NUM_REQ`×`REG_W`: write data per requester.
- `req_ready` out `NUM_REQ`: one-hot or zero grant; a transfer occurs on the cycle where `req_valid[i] && req_ready[i]`.
- `hold` in 1: write port is unavailable this cycle (e.g. debug access). The stage freezes and no grants are issued.
- `rf_wen` out 1: write enable to `rf`.
- `rf_rd` out `REG_A_W`: write address to `rf`.
- `rf_wdata` out `REG_W`: write data to `rf`.
- `pending_mask` out `REG_NUM`: bit k is set when register k (k≠0) has a write in flight, either as a valid request or held in the stage.

## Operation
- Stage state: `stg_valid`, `stg_rd`, `stg_data`. Pointer state: `last` in the range 0..`NUM_REQ`-1.
- Stage can accept when `!hold`; the stage drains every non-hold cycle.
- Grant is combinational. Among the asserted `req_valid`, search starts at index `(last+1) mod NUM_REQ` and wraps; the first hit gets `req_ready`. With `hold`=1 or no valid request, all `req_ready` are 0.
- On a transfer from requester g:
  - `stg_valid`←1, `stg_rd`←`req_rd[g]`, `stg_data`←`req_data[g]`, `last`←g.
- Non-hold cycle with no transfer: `stg_valid`←0. `last` is unchanged.
- `hold`=1: stage and `last` are unchanged.
- `rf_wen` = `stg_valid && !hold && stg_rd != 0 && stg_rd < REG_NUM`. `rf_rd`/`rf_wdata` = stage contents.
- Requests to x0 or to `rd >= REG_NUM` are granted and consume a slot, but never assert `rf_wen`.
- Requesters keep `req_valid`, `req_rd` and `req_data` stable until granted. The arbiter never retracts a grant within a cycle.
- `pending_mask[k]` = (`stg_valid` && `stg_rd`==k) OR (any i: `req_valid[i]` && `req_rd[i]`==k), for k in 1..`REG_NUM`-1. Bit 0 is always 0. Out-of-range rd contributes nothing.
- Two requesters targeting the same rd are both serviced in grant order; the last granted write wins.

## Timing
- Reset values: `stg_valid`=0, `stg_rd`=0, `stg_data`=0, `last`=`NUM_REQ`-1, so requester 0 has first priority. All outputs are 0 during and after reset until a request arrives.
- Reset asserted mid-operation clears the stage; a staged write that has not yet reached `rf` is lost. Requesters must re-issue after reset.
- Latency: a handshake in cycle T loads the stage at edge T→T+1. `rf_wen` is high during T+1, and `rf` is updated at edge T+1→T+2. A read of that register in cycle T+2 returns the new data.
- Throughput: one write per cycle with no bubbles while `!hold`.
- `hold` asserted in cycle T suppresses `rf_wen` and all grants in T. The staged write is issued on the first non-hold cycle.
- Fairness: with all requesters continuously valid, each is granted once every `NUM_REQ` non-hold cycles.

## Structure
- Shared package `rf_pkg`: `REG_NUM`, `REG_A_W`, `REG_W`, `wb_req_t` (valid, rd, data). `rf` and this block both import it.
- Sub-module `rr_arbiter`: parameterized `NUM_REQ`. It takes the request vector, an enable and `last`, and returns a one-hot grant plus an encoded index. It is purely combinational; `last` stays in `rf_wb_arbiter`.

## Test plan
- Reset, then a single write: requester 0 writes rd=5, data=0xDEADBEEF. Expect `req_ready[0]`=1 in cycle T, `rf_wen`=1/`rf_rd`=5 in T+1, and `rf` rdata for 5 = 0xDEADBEEF in T+2.
- Round-robin: all 3 requesters continuously valid with rd=1,2,3 after reset. Expect grants in order 0,1,2,0,1,2, and `rf_wen` high every cycle from T+1.
- Hold: stage loaded with rd=7/0x11, then `hold`=1 for 3 cycles. Expect `rf_wen`=0, all `req_ready`=0 and the stage unchanged. On release, `rf_wen`=1 with rd=7/0x11.
- x0 and out-of-range: requests with rd=0 and rd=20 are granted, `rf_wen` stays 0, and `pending_mask` stays 0.
- Same-rd collision: requesters 1 (0xA) and 2 (0xB) both target rd=4 with `last`=0. Expect 1 granted before 2, final register value 0xB, and `pending_mask[4]` high until the second write completes.
- Reset mid-operation: assert `reset` in the cycle after a handshake. Expect `rf_wen`=0, the register keeps its old value, and `last` returns to `NUM_REQ`-1.

Source files
------------

// File: rtl/rf_pkg.sv
// Register-file shared definitions: sizes, write-back request record and a helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package rf_pkg;

    localparam int REG_NUM = 16;   // architectural registers, x0 hard-wired zero
    localparam int REG_A_W = 5;    // register address width
    localparam int REG_W   = 32;   // register data width

    typedef struct packed {
        logic               valid;
        logic [REG_A_W-1:0] rd;
        logic [REG_W-1:0]   data;
    } wb_req_t;

    // A destination is writable only if it is not x0 and is inside the file.
    function automatic logic rd_writable(input logic [31:0] rd, input int reg_num);
        return (rd != 32'd0) && (rd < 32'(reg_num));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts just after last_i and wraps.
// Latency: zero cycles (purely combinational), pointer state lives in the caller.
// Backpressure: en_i low forces an all-zero grant.
// Ports: req_i request vector, en_i grant enable, last_i previous winner,
//        gnt_o one-hot grant, gnt_idx_o encoded winner, gnt_vld_o any grant.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);

    int idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        if (en_i) begin
            // Offsets 1..NUM_REQ visit every index once, ending on last_i itself.
            for (int off = 1; off <= NUM_REQ; off++) begin
                idx = int'(last_i) + off;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (!gnt_vld_o && (j == idx) && req_i[j]) begin
                        gnt_vld_o = 1'b1;
                        gnt_o[j]  = 1'b1;
                        gnt_idx_o = IDX_W'(j);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: round-robin shares the single rf write port among NUM_REQ producers.
// Latency: handshake in cycle T, rf_wen high in T+1 (one-entry stage), rf updated at end of T+1.
// Backpressure: hold freezes stage and pointer and drops all req_ready; otherwise one write per cycle.
// Ports: clock/reset (sync, active-high); req_valid/req_rd/req_data/req_ready per requester;
//        hold; rf_wen/rf_rd/rf_wdata to the register file; pending_mask for hazard detection.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int REG_NUM = rf_pkg::REG_NUM,
    parameter int REG_A_W = rf_pkg::REG_A_W,
    parameter int REG_W   = rf_pkg::REG_W
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][REG_A_W-1:0]  req_rd,
    input  logic [NUM_REQ-1:0][REG_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             hold,
    output logic                             rf_wen,
    output logic [REG_A_W-1:0]               rf_rd,
    output logic [REG_W-1:0]                 rf_wdata,
    output logic [REG_NUM-1:0]               pending_mask
);
    import rf_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    logic               stg_valid_q, stg_valid_d;
    logic [REG_A_W-1:0] stg_rd_q,    stg_rd_d;
    logic [REG_W-1:0]   stg_data_q,  stg_data_d;
    logic [IDX_W-1:0]   last_q,      last_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;

    // No grants while reset is high: a transfer then would be silently lost.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i     (req_valid),
        .en_i      (!hold && !reset),
        .last_i    (last_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign req_ready = gnt;

    always_comb begin
        stg_valid_d = stg_valid_q;
        stg_rd_d    = stg_rd_q;
        stg_data_d  = stg_data_q;
        last_d      = last_q;
        if (!hold) begin
            if (gnt_vld) begin
                stg_valid_d = 1'b1;
                stg_rd_d    = req_rd[gnt_idx];
                stg_data_d  = req_data[gnt_idx];
                last_d      = gnt_idx;
            end else begin
                // Stage drains every non-hold cycle; rd/data are don't-care once invalid.
                stg_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stg_valid_q <= 1'b0;
            stg_rd_q    <= '0;
            stg_data_q  <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_rd_q    <= stg_rd_d;
            stg_data_q  <= stg_data_d;
            last_q      <= last_d;
        end
    end

    // x0 and out-of-range destinations still consume a slot but never write.
    assign rf_wen   = stg_valid_q && !hold && !reset &&
                      rd_writable(32'(stg_rd_q), REG_NUM);
    assign rf_rd    = stg_rd_q;
    assign rf_wdata = stg_data_q;

    // Looping over k < REG_NUM from 1 drops x0 and out-of-range rd naturally.
    always_comb begin
        pending_mask = '0;
        if (!reset) begin
            for (int k = 1; k < REG_NUM; k++) begin
                if (stg_valid_q && (32'(stg_rd_q) == 32'(k))) begin
                    pending_mask[k] = 1'b1;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && (32'(req_rd[i]) == 32'(k))) begin
                        pending_mask[k] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: per-cycle vector table plus a write scoreboard and rf model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [2:0]           req_valid;
    logic [2:0][4:0]      req_rd;
    logic [2:0][31:0]     req_data;
    logic [2:0]           req_ready;
    logic                 hold;
    logic                 rf_wen;
    logic [4:0]           rf_rd;
    logic [31:0]          rf_wdata;
    logic [15:0]          pending_mask;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clock        (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .hold         (hold),
        .rf_wen       (rf_wen),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask)
    );

    // Simple register file sink driven by the write port.
    logic [31:0] rf_model [0:31];
    always @(posedge clk) begin
        if (rf_wen) rf_model[rf_rd] <= rf_wdata;
    end

    typedef struct {
        logic            rst;
        logic            hold;
        logic [2:0]      v;
        logic [2:0][4:0] rd;
        logic [2:0][31:0] d;
        logic [2:0]      er;    // expected req_ready
        logic            ew;    // expected rf_wen
        logic            crd;   // check rf_rd even without rf_wen
        logic [4:0]      erd;
        logic [15:0]     emask;
    } vec_t;

    vec_t    vt [$];
    wb_req_t sb [$];
    int      checks = 0;
    int      errors = 0;

    function automatic vec_t mk(input logic rst, input logic hld, input logic [2:0] v,
                                input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [2:0] er, input logic ew, input logic crd,
                                input logic [4:0] erd, input logic [15:0] emask);
        vec_t t;
        t.rst = rst; t.hold = hld; t.v = v;
        t.rd[0] = r0; t.rd[1] = r1; t.rd[2] = r2;
        t.d[0] = d0; t.d[1] = d1; t.d[2] = d2;
        t.er = er; t.ew = ew; t.crd = crd; t.erd = erd; t.emask = emask;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    initial begin
        wb_req_t e;
        vec_t    v;
        reset = 1'b1; hold = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;

        //             rst hld v       r0 r1 r2  d0            d1        d2        er      ew crd erd mask
        // single write
        vt.push_back(mk(1, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 0, 0, 16'h0000)); // 0
        vt.push_back(mk(0, 0, 3'b001,  5, 0, 0,  32'hDEADBEEF, 0,        0,        3'b001, 0, 0, 0, 16'h0020)); // 1
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 1, 0, 5, 16'h0020)); // 2
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 0, 0, 16'h0000)); // 3
        // round robin after reset
        vt.push_back(mk(1, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 0, 0, 16'h0000)); // 4
        vt.push_back(mk(0, 0, 3'b111,  1, 2, 3,  32'h100,      32'h200,  32'h300,  3'b001, 0, 0, 0, 16'h000E)); // 5
        vt.push_back(mk(0, 0, 3'b111,  1, 2, 3,  32'h101,      32'h200,  32'h300,  3'b010, 1, 0, 1, 16'h000E)); // 6
        vt.push_back(mk(0, 0, 3'b111,  1, 2, 3,  32'h101,      32'h201,  32'h300,  3'b100, 1, 0, 2, 16'h000E)); // 7
        vt.push_back(mk(0, 0, 3'b111,  1, 2, 3,  32'h101,      32'h201,  32'h301,  3'b001, 1, 0, 3, 16'h000E)); // 8
        vt.push_back(mk(0, 0, 3'b111,  1, 2, 3,  32'h102,      32'h201,  32'h301,  3'b010, 1, 0, 1, 16'h000E)); // 9
        vt.push_back(mk(0, 0, 3'b111,  1, 2, 3,  32'h102,      32'h202,  32'h301,  3'b100, 1, 0, 2, 16'h000E)); // 10
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 1, 0, 3, 16'h0008)); // 11
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 0, 0, 16'h0000)); // 12
        // hold with a waiting request
        vt.push_back(mk(0, 0, 3'b001,  7, 0, 0,  32'h11,       0,        0,        3'b001, 0, 0, 0, 16'h0080)); // 13
        vt.push_back(mk(0, 1, 3'b010,  0, 9, 0,  0,            32'h99,   0,        3'b000, 0, 1, 7, 16'h0280)); // 14
        vt.push_back(mk(0, 1, 3'b010,  0, 9, 0,  0,            32'h99,   0,        3'b000, 0, 1, 7, 16'h0280)); // 15
        vt.push_back(mk(0, 1, 3'b010,  0, 9, 0,  0,            32'h99,   0,        3'b000, 0, 1, 7, 16'h0280)); // 16
        vt.push_back(mk(0, 0, 3'b010,  0, 9, 0,  0,            32'h99,   0,        3'b010, 1, 0, 7, 16'h0280)); // 17
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 1, 0, 9, 16'h0200)); // 18
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 0, 0, 16'h0000)); // 19
        // x0 and out-of-range destinations
        vt.push_back(mk(0, 0, 3'b011,  0, 20, 0, 32'hAA,       32'hBB,   0,        3'b001, 0, 0, 0, 16'h0000)); // 20
        vt.push_back(mk(0, 0, 3'b010,  0, 20, 0, 0,            32'hBB,   0,        3'b010, 0, 1, 0, 16'h0000)); // 21
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 1, 20, 16'h0000)); // 22
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 0, 0, 16'h0000)); // 23
        // same-rd collision with last=0
        vt.push_back(mk(0, 0, 3'b001,  6, 0, 0,  32'h66,       0,        0,        3'b001, 0, 0, 0, 16'h0040)); // 24
        vt.push_back(mk(0, 0, 3'b110,  0, 4, 4,  0,            32'hA,    32'hB,    3'b010, 1, 0, 6, 16'h0050)); // 25
        vt.push_back(mk(0, 0, 3'b100,  0, 0, 4,  0,            0,        32'hB,    3'b100, 1, 0, 4, 16'h0010)); // 26
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 1, 0, 4, 16'h0010)); // 27
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 0, 0, 16'h0000)); // 28
        // reset in the cycle after a handshake
        vt.push_back(mk(0, 0, 3'b001,  4, 0, 0,  32'hCC,       0,        0,        3'b001, 0, 0, 0, 16'h0010)); // 29
        vt.push_back(mk(1, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 0, 0, 16'h0000)); // 30
        vt.push_back(mk(0, 0, 3'b111,  1, 2, 3,  32'h1001,     32'h1002, 32'h1003, 3'b001, 0, 0, 0, 16'h000E)); // 31
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 1, 0, 1, 16'h0002)); // 32
        vt.push_back(mk(0, 0, 3'b000,  0, 0, 0,  0,            0,        0,        3'b000, 0, 0, 0, 16'h0000)); // 33

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            @(posedge clk);
            #1;
            reset     = v.rst;
            hold      = v.hold;
            req_valid = v.v;
            req_rd    = v.rd;
            req_data  = v.d;
            // A staged write not yet issued is lost on reset.
            if (v.rst) sb.delete();
            @(negedge clk);
            chk("req_ready",    i, 32'(req_ready),    32'(v.er));
            chk("rf_wen",       i, 32'(rf_wen),       32'(v.ew));
            chk("pending_mask", i, 32'(pending_mask), 32'(v.emask));
            if (v.ew || v.crd) chk("rf_rd", i, 32'(rf_rd), 32'(v.erd));
            if (rf_wen) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow row %0d: got write rd=%0d with none expected", i, rf_rd);
                end else begin
                    e = sb.pop_front();
                    chk("sb_rd",   i, 32'(rf_rd), 32'(e.rd));
                    chk("sb_data", i, rf_wdata,   e.data);
                end
            end
            for (int g = 0; g < 3; g++) begin
                if (v.er[g] && v.v[g] && v.rd[g] != 5'd0 && v.rd[g] < 5'd16)
                    sb.push_back('{valid: 1'b1, rd: v.rd[g], data: v.d[g]});
            end
        end

        @(posedge clk);
        #1;
        req_valid = '0;
        chk("rf_x5",     99, rf_model[5], 32'hDEADBEEF);
        chk("rf_x4",     99, rf_model[4], 32'h0000000B);
        chk("rf_x1",     99, rf_model[1], 32'h00001001);
        chk("rf_x7",     99, rf_model[7], 32'h00000011);
        chk("sb_left",   99, 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
